// File: rtl/rom_prefetch_if.sv
// rom_prefetch_if: cpu-side and SDRAM-side toggle handshake bundle for rom_prefetch
// master: environment (drives cpu_req/cpu_a, romrd_ack/romrd_q); slave: rom_prefetch
// cpu_req/cpu_ack toggle pair with cpu_a word address and cpu_q read data
// romrd_req/romrd_ack toggle pair with romrd_a word address and romrd_q read data
interface rom_prefetch_if;
  logic        cpu_req;
  logic [22:0] cpu_a;
  logic        cpu_ack;
  logic [15:0] cpu_q;
  logic        romrd_req;
  logic        romrd_ack;
  logic [22:0] romrd_a;
  logic [15:0] romrd_q;
  modport master (
    output cpu_req, cpu_a, romrd_ack, romrd_q,
    input  cpu_ack, cpu_q, romrd_req, romrd_a
  );
  modport slave (
    input  cpu_req, cpu_a, romrd_ack, romrd_q,
    output cpu_ack, cpu_q, romrd_req, romrd_a
  );
endinterface

// File: rtl/rom_prefetch.sv
// rom_prefetch: 2-entry word buffer (last demand L, sequential prefetch P) between 68k ROM reads and SDRAM
// clk: posedge clock; reset: sync active-high; flush: invalidate both entries
// bus.cpu_*: toggle read port from the 68k decoder; bus.romrd_*: toggle read port to SDRAM
module rom_prefetch #(
  parameter bit          PREFETCH_EN = 1'b1,
  parameter logic [22:0] PF_STRIDE   = 23'd1
) (
  input logic clk,
  input logic reset,
  input logic flush,
  rom_prefetch_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, PREF = 2'd2;
  logic [1:0] state;
  logic l_valid, p_valid, discard, cpu_ack, romrd_req;
  logic [22:0] l_a, p_a, romrd_a, nxt;
  logic [15:0] l_d, p_d, cpu_q;
  logic pending, sd_done, hit_l, hit_p, pf_go, drop;
  assign bus.cpu_ack = cpu_ack;
  assign bus.cpu_q = cpu_q;
  assign bus.romrd_req = romrd_req;
  assign bus.romrd_a = romrd_a;
  // flush in the lookup cycle forces a miss; pf_go skips the prefetch when P already holds the next word
  always_comb begin
    pending = bus.cpu_req ^ cpu_ack;
    sd_done = romrd_req == bus.romrd_ack;
    hit_l = l_valid && l_a == bus.cpu_a && !flush;
    hit_p = p_valid && p_a == bus.cpu_a && !flush;
    nxt = bus.cpu_a + PF_STRIDE;
    pf_go = PREFETCH_EN && !(p_valid && !hit_p && !flush && p_a == nxt);
    drop = discard || flush;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      l_valid <= 1'b0;
      p_valid <= 1'b0;
      discard <= 1'b0;
      cpu_q <= '0;
      romrd_a <= '0;
      cpu_ack <= bus.cpu_req;
      romrd_req <= bus.romrd_ack;
    end else begin
      if (state == IDLE && pending && (hit_l || hit_p)) begin
        cpu_q <= hit_p ? p_d : l_d;
        cpu_ack <= bus.cpu_req;
        if (hit_p) begin
          l_a <= p_a;
          l_d <= p_d;
          l_valid <= 1'b1;
          p_valid <= 1'b0;
        end
        if (pf_go) begin
          romrd_a <= nxt;
          romrd_req <= ~romrd_req;
          discard <= 1'b0;
          state <= PREF;
        end
      end else if (state == IDLE && pending) begin
        romrd_a <= bus.cpu_a;
        romrd_req <= ~romrd_req;
        discard <= 1'b0;
        state <= FETCH;
      end else if (state == FETCH && sd_done) begin
        cpu_q <= bus.romrd_q;
        cpu_ack <= bus.cpu_req;
        l_a <= bus.cpu_a;
        l_d <= bus.romrd_q;
        l_valid <= !discard;
        if (pf_go) romrd_a <= nxt;
        romrd_req <= romrd_req ^ pf_go;
        discard <= 1'b0;
        state <= pf_go ? PREF : IDLE;
      end else if (state == PREF && sd_done) begin
        p_a <= romrd_a;
        p_d <= bus.romrd_q;
        p_valid <= !drop;
        discard <= 1'b0;
        // the word just fetched is the one the cpu waits for: serve it now and move it straight to L
        if (!drop && pending && bus.cpu_a == romrd_a) begin
          cpu_q <= bus.romrd_q;
          cpu_ack <= bus.cpu_req;
          l_a <= romrd_a;
          l_d <= bus.romrd_q;
          l_valid <= 1'b1;
          p_valid <= 1'b0;
          romrd_a <= nxt;
          romrd_req <= ~romrd_req;
        end else begin
          state <= IDLE;
        end
      end else if (state != IDLE && flush) begin
        discard <= 1'b1;
      end
      if (flush) begin
        l_valid <= 1'b0;
        p_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rom_prefetch.sv
// tb_rom_prefetch: directed + randomized check of rom_prefetch against a transaction-level buffer model
module tb_rom_prefetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  rom_prefetch_if bus();
  rom_prefetch dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  function automatic logic [15:0] rom(input logic [22:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask
  // SDRAM port: answers a pending toggle after sd_lat clocks, ack <= req, data from the ROM image
  int sd_lat = 8;
  bit sd_busy = 0;
  int sd_cnt;
  logic [22:0] sd_addr;
  logic sd_tog;
  initial begin
    bus.romrd_ack = 1'b0;
    bus.romrd_q = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.romrd_q = 16'($urandom);
      if (sd_busy) begin
        sd_cnt--;
        if (sd_cnt == 0) begin
          sd_busy = 0;
          if (bus.romrd_req === sd_tog) begin
            bus.romrd_ack = sd_tog;
            bus.romrd_q = rom(sd_addr);
          end
        end
      end else if (!reset && bus.romrd_req !== bus.romrd_ack) begin
        sd_busy = 1;
        sd_cnt = sd_lat;
        sd_addr = bus.romrd_a;
        sd_tog = bus.romrd_req;
      end
    end
  end
  // Reference: entries held as addresses (-1 = empty), data always rom(addr);
  // busy: 0 nothing outstanding, 1 demand outstanding, 2 prefetch outstanding
  int la, pa, busy;
  bit taint;
  bit model_ok = 0;
  logic e_ack, e_req;
  logic [15:0] e_q;
  logic [22:0] e_a;
  task automatic serve(input logic [22:0] a);
    e_ack = bus.cpu_req;
    e_q = rom(a);
  endtask
  task automatic chain(input logic [22:0] a);
    logic [22:0] n;
    n = a + 23'd1;
    if (pa != int'(n)) begin
      e_a = n;
      e_req = ~e_req;
      busy = 2;
      taint = 0;
    end else begin
      busy = 0;
    end
  endtask
  task automatic model_step();
    logic pend, done;
    logic [22:0] a;
    if (reset) begin
      busy = 0; la = -1; pa = -1; taint = 0;
      e_q = '0; e_a = '0;
      e_req = bus.romrd_ack;
      e_ack = bus.cpu_req;
      model_ok = 1;
      return;
    end
    if (!model_ok) return;
    pend = bus.cpu_req != e_ack;
    done = e_req == bus.romrd_ack;
    a = bus.cpu_a;
    if (flush) begin
      la = -1;
      pa = -1;
    end
    if (busy == 0) begin
      if (pend) begin
        if (la == int'(a) || pa == int'(a)) begin
          serve(a);
          if (pa == int'(a)) begin
            la = pa;
            pa = -1;
          end
          chain(a);
        end else begin
          e_a = a;
          e_req = ~e_req;
          busy = 1;
          taint = 0;
        end
      end
    end else if (done) begin
      if (busy == 1) begin
        serve(a);
        if (!taint && !flush) la = int'(a);
        chain(a);
      end else if (taint || flush) begin
        busy = 0;
      end else begin
        pa = int'(e_a);
        if (pend && a == e_a) begin
          serve(a);
          la = pa;
          pa = -1;
          chain(a);
        end else begin
          busy = 0;
        end
      end
    end else if (flush) begin
      taint = 1;
    end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  // compare every cycle, and log SDRAM issues / cpu acks outside reset for directed checks
  logic [22:0] issues[$];
  int ack_toggles = 0;
  bit mon_init = 0;
  logic prev_req, prev_ack;
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("cpu_ack", 32'(bus.cpu_ack), 32'(e_ack));
      check("cpu_q", 32'(bus.cpu_q), 32'(e_q));
      check("romrd_req", 32'(bus.romrd_req), 32'(e_req));
      check("romrd_a", 32'(bus.romrd_a), 32'(e_a));
      if (mon_init && !reset) begin
        if (bus.romrd_req !== prev_req) issues.push_back(bus.romrd_a);
        if (bus.cpu_ack !== prev_ack) ack_toggles++;
      end
      prev_req = bus.romrd_req;
      prev_ack = bus.cpu_ack;
      mon_init = 1;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic read(input logic [22:0] a, output int lat);
    bus.cpu_a = a;
    bus.cpu_req = ~bus.cpu_req;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.cpu_ack !== bus.cpu_req && lat < 300);
    if (lat >= 300) check("read_timeout", 32'(bus.cpu_ack), 32'(bus.cpu_req));
    tick();
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.romrd_req !== bus.romrd_ack || sd_busy) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(bus.romrd_req), 32'(bus.romrd_ack));
    tick();
    tick();
  endtask
  task automatic do_reset();
    int n;
    reset = 1'b1;
    tick();
    tick();
    n = 0;
    while (sd_busy && n < 50) begin
      tick();
      n++;
    end
    reset = 1'b0;
  endtask
  initial begin
    int lat, n0, n1, wait_cnt;
    logic [22:0] last, addr;
    bit abort;
    bus.cpu_req = 1'b0;
    bus.cpu_a = '0;
    repeat (3) tick();
    check("rst_cpu_ack", 32'(bus.cpu_ack), 32'(bus.cpu_req));
    check("rst_romrd_req", 32'(bus.romrd_req), 32'(bus.romrd_ack));
    check("rst_cpu_q", 32'(bus.cpu_q), 32'h0);
    check("rst_romrd_a", 32'(bus.romrd_a), 32'h0);
    reset = 1'b0;
    tick();
    // 1: cold miss, then sequential prefetch of the next word
    read(23'h000100, lat);
    check("t1_miss_lat", 32'(lat), 32'd11);
    check("t1_q", 32'(bus.cpu_q), 32'hA4C3);
    check("t1_issues", 32'(issues.size()), 32'd2);
    check("t1_demand_a", 32'(issues[0]), 32'h000100);
    check("t1_pref_a", 32'(issues[1]), 32'h000101);
    // 2: prefetched word hits, next prefetch goes out
    wait_idle();
    read(23'h000101, lat);
    check("t2_hit_lat", 32'(lat), 32'd2);
    check("t2_q", 32'(bus.cpu_q), 32'hA4C2);
    check("t2_issues", 32'(issues.size()), 32'd3);
    check("t2_pref_a", 32'(issues[2]), 32'h000102);
    // 3: repeated L hits, P already holds the next word so nothing is issued
    wait_idle();
    read(23'h000101, lat);
    check("t3_hit_lat_a", 32'(lat), 32'd2);
    read(23'h000101, lat);
    check("t3_hit_lat_b", 32'(lat), 32'd2);
    check("t3_q", 32'(bus.cpu_q), 32'hA4C2);
    check("t3_issues", 32'(issues.size()), 32'd3);
    // 4: top of the address space wraps the prefetch to zero
    read(23'h7FFFFF, lat);
    check("t4_miss_lat", 32'(lat), 32'd11);
    check("t4_q", 32'(bus.cpu_q), 32'h5A3C);
    check("t4_pref_wrap", 32'(issues[4]), 32'h000000);
    wait_idle();
    read(23'h000000, lat);
    check("t4_wrap_hit_lat", 32'(lat), 32'd2);
    check("t4_wrap_q", 32'(bus.cpu_q), 32'hA5C3);
    wait_idle();
    // 5: unrelated miss waits behind an in-flight prefetch
    read(23'h000101, lat);
    check("t5_miss_lat", 32'(lat), 32'd11);
    read(23'h000200, lat);
    check("t5_behind_pref_lat", 32'(lat), 32'd19);
    check("t5_order_pref", 32'(issues[7]), 32'h000102);
    check("t5_order_demand", 32'(issues[8]), 32'h000200);
    wait_idle();
    read(23'h000102, lat);
    check("t5_evicted_lat", 32'(lat), 32'd11);
    check("t5_evicted_demand", 32'(issues[10]), 32'h000102);
    // 6: flush while the 0x103 prefetch is in flight drops it
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle();
    read(23'h000103, lat);
    check("t6_flushed_lat", 32'(lat), 32'd11);
    check("t6_demand_a", 32'(issues[12]), 32'h000103);
    wait_idle();
    // 7: reset during a demand fetch with SDRAM still busy
    bus.cpu_a = 23'h000300;
    bus.cpu_req = ~bus.cpu_req;
    repeat (3) tick();
    check("t7_demand_a", 32'(issues[issues.size() - 1]), 32'h000300);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("t7_romrd_idle", 32'(bus.romrd_req), 32'(bus.romrd_ack));
    check("t7_cpu_idle", 32'(bus.cpu_ack), 32'(bus.cpu_req));
    n0 = ack_toggles;
    n1 = issues.size();
    repeat (15) tick();
    check("t7_no_late_ack", 32'(ack_toggles), 32'(n0));
    check("t7_no_new_issue", 32'(issues.size()), 32'(n1));
    check("t7_romrd_still_idle", 32'(bus.romrd_req), 32'(bus.romrd_ack));
    // random phase
    last = 23'h000400;
    wait_cnt = 0;
    abort = 0;
    for (int i = 0; i < 4000 && !abort; i++) begin
      flush = $urandom_range(0, 99) < 4;
      sd_lat = $urandom_range(1, 6);
      if (bus.cpu_ack === bus.cpu_req) begin
        wait_cnt = 0;
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: addr = last + 23'd1;
            5: addr = last;
            6: addr = last + 23'd2;
            7: addr = 23'h7FFFF0 + 23'($urandom_range(0, 15));
            8: addr = 23'($urandom_range(0, 15));
            default: addr = 23'($urandom);
          endcase
          bus.cpu_a = addr;
          bus.cpu_req = ~bus.cpu_req;
          last = addr;
        end
      end else begin
        wait_cnt++;
        if (wait_cnt > 100) begin
          check("pending_bound", 32'(bus.cpu_ack), 32'(bus.cpu_req));
          abort = 1;
        end
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end
    flush = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
